// File: rtl/addsub_arbiter.sv
// Round-robin two-requester front end for the shared 3-bit adder/subtractor.
// Define ADDSUB_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module addsub_arbiter #(
    parameter int W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [2*W-1:0] req_x,
    input  logic [2*W-1:0] req_y,
    input  logic [1:0]     req_m,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_sum,
    output logic           resp_cout,
    output logic           resp_ovf,
    output logic [W-1:0]   au_x,
    output logic [W-1:0]   au_y,
    output logic           au_m,
    input  logic [W-1:0]   au_sum,
    input  logic           au_cout,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    logic         grant;
    logic         pick;
    logic [W-1:0] y_eff;
    logic         ovf;

`ifdef ADDSUB_ARB_FIXED_PRIO_EN
    assign pick = ~req_valid[0];
`else
    logic last;

    // On a tie the requester that was not served last wins.
    assign pick = (req_valid[0] & req_valid[1]) ? ~last : req_valid[1];
`endif

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && |req_valid)
            req_ready = pick ? 2'b10 : 2'b01;
    end

    assign y_eff = au_y ^ {W{au_m}};
    assign ovf   = (au_x[W-1] == y_eff[W-1]) && (au_sum[W-1] != au_x[W-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            au_x       <= '0;
            au_y       <= '0;
            au_m       <= 1'b0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_ovf   <= 1'b0;
            resp_valid <= 2'b00;
            busy       <= 1'b0;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
            last       <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_valid) begin
                        grant <= pick;
                        au_x  <= pick ? req_x[2*W-1:W] : req_x[W-1:0];
                        au_y  <= pick ? req_y[2*W-1:W] : req_y[W-1:0];
                        au_m  <= pick ? req_m[1] : req_m[0];
                        busy  <= 1'b1;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    resp_sum   <= au_sum;
                    resp_cout  <= au_cout;
                    resp_ovf   <= ovf;
                    resp_valid <= grant ? 2'b10 : 2'b01;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready[grant]) begin
                        resp_valid <= 2'b00;
                        busy       <= 1'b0;
                        state      <= IDLE;
`ifndef ADDSUB_ARB_FIXED_PRIO_EN
                        last       <= grant;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Randomized self-checking bench for addsub_arbiter with an arithmetic
// reference model and a behavioural adder/subtractor on the au_* side.
module tb_addsub_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [5:0] req_x;
    logic [5:0] req_y;
    logic [1:0] req_m;
    logic [1:0] resp_valid;
    logic [1:0] resp_ready;
    logic [2:0] resp_sum;
    logic       resp_cout;
    logic       resp_ovf;
    logic [2:0] au_x;
    logic [2:0] au_y;
    logic       au_m;
    logic [2:0] au_sum;
    logic       au_cout;
    logic       busy;

    int checks = 0;
    int errors = 0;

    addsub_arbiter #(.W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_m     (req_m),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_sum  (resp_sum),
        .resp_cout (resp_cout),
        .resp_ovf  (resp_ovf),
        .au_x      (au_x),
        .au_y      (au_y),
        .au_m      (au_m),
        .au_sum    (au_sum),
        .au_cout   (au_cout),
        .busy      (busy)
    );

    // Behavioural stand-in for the combinational adder/subtractor.
    logic [3:0] au_full;
    assign au_full = au_m ? ({1'b0, au_x} + {1'b0, ~au_y} + 4'd1)
                          : ({1'b0, au_x} + {1'b0, au_y});
    assign au_sum  = au_full[2:0];
    assign au_cout = au_full[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference result {ovf, cout, sum[2:0]} from plain integer arithmetic.
    function automatic logic [4:0] ref_op(input int x, input int y, input int m);
        int sx;
        int sy;
        int ru;
        int rs;
        logic [2:0] s;
        logic c;
        logic o;
        sx = (x > 3) ? x - 8 : x;
        sy = (y > 3) ? y - 8 : y;
        ru = m ? x - y : x + y;
        rs = m ? sx - sy : sx + sy;
        s = 3'((ru + 16) % 8);
        c = m ? (x >= y) : (ru > 7);
        o = (rs > 3) || (rs < -4);
        return {o, c, s};
    endfunction

    function automatic logic [1:0] onehot(input int r);
        return (r == 1) ? 2'b10 : 2'b01;
    endfunction

    // Issues one request from requester r and collects its response;
    // lat counts cycles from the handshake cycle, -1 if nothing arrived.
    task automatic run_op(input int r, input int x, input int y, input int m,
                          output logic [4:0] got, output int lat);
        int n;
        @(posedge clk);
        #1;
        req_x[r*3 +: 3] = 3'(x);
        req_y[r*3 +: 3] = 3'(y);
        req_m[r]        = m[0];
        req_valid[r]    = 1'b1;
        #1;
        n = 0;
        while (!req_ready[r] && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        lat = 0;
        got = '0;
        do begin
            @(posedge clk);
            #1;
            req_valid[r] = 1'b0;
            lat++;
        end while (!resp_valid[r] && lat < 10);
        if (!resp_valid[r]) begin
            lat = -1;
        end else begin
            got = {resp_ovf, resp_cout, resp_sum};
        end
        resp_ready[r] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[r] = 1'b0;
    endtask

    task automatic test_reset;
        if ({req_ready, resp_valid, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b rv=%b busy=%b, want 0", req_ready, resp_valid, busy);
        end
        checks++;
        if ({resp_sum, resp_cout, resp_ovf, au_x, au_y, au_m} !== 12'b0) begin
            errors++;
            $display("FAIL reset_data: got sum=%0d c=%b o=%b ax=%0d ay=%0d am=%b, want 0",
                     resp_sum, resp_cout, resp_ovf, au_x, au_y, au_m);
        end
        checks++;
    endtask

    task automatic test_basic;
        int vec[4][3] = '{'{3, 2, 0}, '{3, 2, 1}, '{1, 3, 1}, '{1, 3, 0}};
        int req[4] = '{0, 1, 0, 0};
        logic [4:0] got;
        logic [4:0] exp;
        int lat;
        for (int i = 0; i < 4; i++) begin
            exp = ref_op(vec[i][0], vec[i][1], vec[i][2]);
            run_op(req[i], vec[i][0], vec[i][1], vec[i][2], got, lat);
            if (lat !== 2) begin
                errors++;
                $display("FAIL basic_lat[%0d]: got %0d cycles, want 2", i, lat);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL basic_res[%0d]: got {ovf,cout,sum}=%b, want %b", i, got, exp);
            end
            checks++;
        end
    endtask

    task automatic test_random;
        logic [4:0] got;
        logic [4:0] exp;
        int lat;
        int r, x, y, m;
        for (int i = 0; i < 24; i++) begin
            r = int'($urandom_range(1, 0));
            x = int'($urandom_range(7, 0));
            y = int'($urandom_range(7, 0));
            m = int'($urandom_range(1, 0));
            exp = ref_op(x, y, m);
            run_op(r, x, y, m, got, lat);
            if (lat !== 2 || got !== exp) begin
                errors++;
                $display("FAIL rand[%0d]: r=%0d x=%0d y=%0d m=%0d got lat=%0d res=%b, want lat=2 res=%b",
                         i, r, x, y, m, lat, got, exp);
            end
            checks++;
        end
    endtask

    task automatic test_round_robin;
        int ox[2];
        int oy[2];
        int om[2];
        int last_m;
        int g;
        logic [1:0] exp_rdy;
        logic [4:0] exp;
        for (int r = 0; r < 2; r++) begin
            ox[r] = int'($urandom_range(7, 0));
            oy[r] = int'($urandom_range(7, 0));
            om[r] = int'($urandom_range(1, 0));
            req_x[r*3 +: 3] = 3'(ox[r]);
            req_y[r*3 +: 3] = 3'(oy[r]);
            req_m[r]        = om[r][0];
        end
        rst = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_m = 1;
        g = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
`ifdef ADDSUB_ARB_FIXED_PRIO_EN
            if (k % 3 == 0) g = 0;
`else
            if (k % 3 == 0) g = 1 - last_m;
`endif
            exp_rdy = (k % 3 == 0) ? onehot(g) : 2'b00;
            if (req_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got req_ready=%b, want %b", k, req_ready, exp_rdy);
            end
            checks++;
            if (k % 3 == 2) begin
                exp = ref_op(ox[g], oy[g], om[g]);
                if (resp_valid !== onehot(g) || {resp_ovf, resp_cout, resp_sum} !== exp) begin
                    errors++;
                    $display("FAIL rr_resp[%0d]: got rv=%b res=%b, want rv=%b res=%b",
                             k, resp_valid, {resp_ovf, resp_cout, resp_sum}, onehot(g), exp);
                end
                checks++;
                last_m = g;
            end else if (resp_valid !== 2'b00) begin
                errors++;
                $display("FAIL rr_idle_resp[%0d]: got rv=%b, want 00", k, resp_valid);
            end
            @(posedge clk);
            #1;
        end
        req_valid  = 2'b00;
        resp_ready = 2'b00;
    endtask

    task automatic test_stall;
        int x0, y0, m0, x1, y1, m1;
        logic [4:0] exp0;
        logic [4:0] exp1;
        x0 = int'($urandom_range(7, 0));
        y0 = int'($urandom_range(7, 0));
        m0 = int'($urandom_range(1, 0));
        x1 = int'($urandom_range(7, 0));
        y1 = int'($urandom_range(7, 0));
        m1 = int'($urandom_range(1, 0));
        exp0 = ref_op(x0, y0, m0);
        exp1 = ref_op(x1, y1, m1);
        @(posedge clk);
        #1;
        req_x = {3'(x1), 3'(x0)};
        req_y = {3'(y1), 3'(y0)};
        req_m = {m1[0], m0[0]};
        req_valid = 2'b01;
        #1;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL stall_accept: got req_ready=%b, want 01", req_ready);
        end
        checks++;
        @(posedge clk);
        #1;
        req_valid = 2'b10;
        #1;
        if (req_ready !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_exec: got req_ready=%b busy=%b, want 00 1", req_ready, busy);
        end
        checks++;
        @(posedge clk);
        #1;
        resp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 2'b01 || {resp_ovf, resp_cout, resp_sum} !== exp0 ||
                req_ready !== 2'b00 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got rv=%b res=%b rdy=%b busy=%b, want 01 %b 00 1",
                         i, resp_valid, {resp_ovf, resp_cout, resp_sum}, req_ready, busy, exp0);
            end
            checks++;
        end
        resp_ready = 2'b01;
        @(posedge clk);
        #1;
        resp_ready = 2'b00;
        #1;
        if (resp_valid !== 2'b00 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL stall_release: got rv=%b rdy=%b, want 00 10", resp_valid, req_ready);
        end
        checks++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        if (resp_valid !== 2'b10 || {resp_ovf, resp_cout, resp_sum} !== exp1) begin
            errors++;
            $display("FAIL stall_next: got rv=%b res=%b, want 10 %b",
                     resp_valid, {resp_ovf, resp_cout, resp_sum}, exp1);
        end
        checks++;
        resp_ready = 2'b10;
        @(posedge clk);
        #1;
        resp_ready = 2'b00;
    endtask

    task automatic test_reset_exec;
        int x, y, m;
        logic [4:0] exp;
        @(posedge clk);
        #1;
        req_x = {3'd5, 3'd6};
        req_y = {3'd2, 3'd7};
        req_m = 2'b10;
        req_valid = 2'b10;
        #1;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rexec_accept: got req_ready=%b, want 10", req_ready);
        end
        checks++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rexec_busy: got busy=%b, want 1", busy);
        end
        checks++;
        rst = 1'b1;
        #1;
        if ({busy, resp_valid, resp_sum, resp_cout, resp_ovf, au_x, au_y, au_m} !== 15'b0) begin
            errors++;
            $display("FAIL rexec_clear: got busy=%b rv=%b sum=%0d ax=%0d ay=%0d am=%b, want 0",
                     busy, resp_valid, resp_sum, au_x, au_y, au_m);
        end
        checks++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (resp_valid !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rexec_noresp: got rv=%b busy=%b, want 00 0", resp_valid, busy);
        end
        checks++;
        x = int'($urandom_range(7, 0));
        y = int'($urandom_range(7, 0));
        m = int'($urandom_range(1, 0));
        exp = ref_op(x, y, m);
        req_x = {3'd1, 3'(x)};
        req_y = {3'd1, 3'(y)};
        req_m = {1'b0, m[0]};
        req_valid = 2'b11;
        #1;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rexec_tie: got req_ready=%b, want 01", req_ready);
        end
        checks++;
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        if (resp_valid !== 2'b01 || {resp_ovf, resp_cout, resp_sum} !== exp) begin
            errors++;
            $display("FAIL rexec_result: got rv=%b res=%b, want 01 %b",
                     resp_valid, {resp_ovf, resp_cout, resp_sum}, exp);
        end
        checks++;
        resp_ready = 2'b01;
        @(posedge clk);
        #1;
        resp_ready = 2'b00;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 2'b00;
        req_x      = '0;
        req_y      = '0;
        req_m      = 2'b00;
        resp_ready = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_basic;
        test_random;
        test_round_robin;
        test_stall;
        test_reset_exec;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
